// File: rtl/triple_mul_seq.sv
`timescale 1ns/1ps
// Three-operand unsigned product y = a*b*c on one shared shift-add adder.
// Two 12-step multiply phases, then a write-back that overwrites or accumulates into y.
module triple_mul_seq #(
  parameter int unsigned W_OP = 12,
  parameter int unsigned W_Y  = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_OP-1:0]   a,
  input  logic [W_OP-1:0]   b,
  input  logic [W_OP-1:0]   c,
  input  logic              e,
  input  logic              clr,
  output logic              out_valid,
  output logic [W_Y-1:0]    y
);

  localparam int unsigned W_P1 = 2 * W_OP;
  localparam int unsigned W_P  = 3 * W_OP;
  localparam logic [3:0]  LastBit = 4'(W_OP - 1);

  typedef enum logic [1:0] {StIdle, StMul1, StMul2, StWb} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [W_OP-1:0]   a_q, a_d;
  logic [W_OP-1:0]   b_q, b_d;
  logic [W_OP-1:0]   c_q, c_d;
  logic              e_q, e_d;
  logic [W_P1-1:0]   p1_q, p1_d;
  logic [W_P-1:0]    p_q, p_d;
  logic [W_Y-1:0]    y_q, y_d;
  logic              out_valid_q, out_valid_d;

  logic              accept;
  logic              last_step;
  logic              bit_sel;
  logic [W_P-1:0]    addend;
  logic [W_P-1:0]    sum;

  assign accept    = in_valid & in_ready;
  assign last_step = (cnt_q == LastBit);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept)    state_d = StMul1;
      StMul1: if (last_step) state_d = StMul2;
      StMul2: if (last_step) state_d = StWb;
      StWb:                  state_d = StIdle;
      default:               state_d = StIdle;
    endcase
  end

  // Output logic: in_ready depends on state only
  always_comb begin
    in_ready = (state_q == StIdle);
  end

  // Shared adder: MUL1 adds shifted a under b, MUL2 adds shifted P1 under c
  always_comb begin
    bit_sel = 1'b0;
    addend  = '0;
    if (state_q == StMul1) begin
      bit_sel = b_q[cnt_q];
      addend  = bit_sel ? ({{(W_P - W_OP){1'b0}}, a_q} << cnt_q) : '0;
    end else if (state_q == StMul2) begin
      bit_sel = c_q[cnt_q];
      addend  = bit_sel ? ({{(W_P - W_P1){1'b0}}, p1_q} << cnt_q) : '0;
    end
    sum = p_q + addend;
  end

  // Datapath next-state
  always_comb begin
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    e_d         = e_q;
    p1_d        = p1_q;
    p_d         = p_q;
    y_d         = y_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr) begin
          y_d = '0;
        end
        if (accept) begin
          a_d   = a;
          b_d   = b;
          c_d   = c;
          e_d   = e;
          p_d   = '0;
          cnt_d = '0;
        end
      end
      StMul1: begin
        if (last_step) begin
          p1_d  = sum[W_P1-1:0];
          p_d   = '0;
          cnt_d = '0;
        end else begin
          p_d   = sum;
          cnt_d = cnt_q + 4'd1;
        end
      end
      StMul2: begin
        p_d = sum;
        if (last_step) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWb: begin
        // Accumulation wraps modulo 2^W_Y
        y_d         = e_q ? (y_q + {{(W_Y - W_P){1'b0}}, p_q})
                          : {{(W_Y - W_P){1'b0}}, p_q};
        out_valid_d = 1'b1;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      e_q         <= 1'b0;
      p1_q        <= '0;
      p_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      e_q         <= e_d;
      p1_q        <= p1_d;
      p_q         <= p_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_triple_mul_seq.sv
`timescale 1ns/1ps
// Directed bench for triple_mul_seq: reset, overwrite, back-to-back accumulate,
// wrap, clr interactions and mid-operation reset.
module tb_triple_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a, b, c;
  logic        e;
  logic        clr;
  logic        out_valid;
  logic [39:0] y;

  int checks = 0;
  int errors = 0;

  triple_mul_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .e         (e),
    .clr       (clr),
    .out_valid (out_valid),
    .y         (y)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: accept one op from idle, scramble inputs while busy,
  // return edges-to-out_valid (40 means it never came) and y at that point.
  task automatic run_op(input logic [11:0] ia, input logic [11:0] ib, input logic [11:0] ic,
                        input logic ie, input logic iclr, output int lat,
                        output logic [39:0] yv);
    a = ia; b = ib; c = ic; e = ie; clr = iclr; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; clr = 1'b0;
    a = ~ia; b = ~ib; c = ~ic; e = ~ie;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (out_valid === 1'b1) break;
    end
    yv = y;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; a = '0; b = '0; c = '0; e = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    checks++; if (y !== 40'h0) begin errors++; $display("FAIL reset_y got %h exp 0", y); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", in_ready); end
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (y !== 40'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_hold cyc %0d got y=%h ov=%b rdy=%b exp y=0 ov=0 rdy=1",
                 i, y, out_valid, in_ready);
      end
    end
  endtask

  // in_valid stays high afterwards so the next op is accepted back-to-back
  task automatic test_overwrite();
    a = 12'h76C; b = 12'h020; c = 12'h0A5; e = 1'b0; in_valid = 1'b1;
    tick();
    e = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL ow_busy before edge k+%0d got rdy=%b ov=%b exp rdy=0 ov=0",
                 i, in_ready, out_valid);
      end
      tick();
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ow_ov got %b exp 1", out_valid); end
    checks++; if (y !== 40'h00_0099_1380) begin errors++; $display("FAIL ow_y got %h exp 0000991380", y); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ow_rdy got %b exp 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_ov_fall got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got rdy=%b exp 0", in_ready); end
    checks++; if (y !== 40'h00_0099_1380) begin errors++; $display("FAIL b2b_y_hold got %h exp 0000991380", y); end
    a = 12'hFFF; b = 12'h000; c = 12'h123; e = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (out_valid === 1'b1) break;
    end
    checks++; if (lat !== 25) begin errors++; $display("FAIL b2b_lat got %0d exp 25", lat); end
    checks++; if (y !== 40'h00_0132_2700) begin errors++; $display("FAIL b2b_y got %h exp 0001322700", y); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse got %b exp 0", out_valid); end
  endtask

  task automatic test_max_wrap();
    int lat;
    logic [39:0] yv;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (y !== 40'h0) begin errors++; $display("FAIL clr_idle got %h exp 0", y); end
    for (int k = 1; k <= 17; k++) begin
      run_op(12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 1'b0, lat, yv);
      checks++; if (lat !== 25) begin errors++; $display("FAIL max_lat op %0d got %0d exp 25", k, lat); end
      if (k == 1) begin
        checks++;
        if (yv !== 40'h0F_FD00_2FFF) begin errors++; $display("FAIL max_1 got %h exp 0FFD002FFF", yv); end
      end
      if (k == 16) begin
        checks++;
        if (yv !== 40'hFF_D002_FFF0) begin errors++; $display("FAIL max_16 got %h exp FFD002FFF0", yv); end
      end
      if (k == 17) begin
        checks++;
        if (yv !== 40'h0F_CD03_2FEF) begin errors++; $display("FAIL wrap_17 got %h exp 0FCD032FEF", yv); end
      end
    end
  endtask

  task automatic test_clr();
    int lat;
    logic [39:0] yv;
    a = 12'h001; b = 12'h001; c = 12'h001; e = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    checks++; if (y !== 40'h0F_CD03_2FEF) begin errors++; $display("FAIL clr_busy got %h exp 0FCD032FEF", y); end
    lat = 16;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) break;
      tick();
      lat++;
    end
    checks++; if (lat !== 25) begin errors++; $display("FAIL clr_busy_lat got %0d exp 25", lat); end
    checks++; if (y !== 40'h0F_CD03_2FF0) begin errors++; $display("FAIL clr_busy_acc got %h exp 0FCD032FF0", y); end
    run_op(12'h001, 12'h001, 12'h001, 1'b1, 1'b1, lat, yv);
    checks++; if (lat !== 25) begin errors++; $display("FAIL clr_acc_lat got %0d exp 25", lat); end
    checks++; if (yv !== 40'h1) begin errors++; $display("FAIL clr_acc_y got %h exp 1", yv); end
  endtask

  task automatic test_reset_midop();
    int lat;
    logic [39:0] yv;
    a = 12'h76C; b = 12'h020; c = 12'h0A5; e = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (y !== 40'h0) begin errors++; $display("FAIL rst_mid_y got %h exp 0", y); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ov got %b exp 0", out_valid); end
    repeat (3) tick();
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_rdy got %b exp 1", in_ready); end
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || y !== 40'h0) begin
        errors++;
        $display("FAIL rst_stray cyc %0d got ov=%b y=%h exp ov=0 y=0", i, out_valid, y);
      end
    end
    run_op(12'h76C, 12'h020, 12'h0A5, 1'b1, 1'b0, lat, yv);
    checks++; if (lat !== 25) begin errors++; $display("FAIL rst_next_lat got %0d exp 25", lat); end
    checks++; if (yv !== 40'h00_0099_1380) begin errors++; $display("FAIL rst_next_y got %h exp 0000991380", yv); end
  endtask

  initial begin
    test_reset();
    test_overwrite();
    test_back_to_back();
    test_max_wrap();
    test_clr();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/triple_mul_seq.md
# triple_mul_seq

Sequencing controller for the three-operand product datapath. It accepts unsigned 12-bit operands a, b, c and computes y = a*b*c using one shared shift-add adder, over two 12-cycle multiply phases. Mode bit e selects overwrite or accumulate into a 40-bit result register. It sits between the operand source and the 40-bit y consumer in the top-level design, and replaces a flat combinational product with a small, time-multiplexed one.

## Interface
- W_OP, 12, operand width (fixed; the design is not required to support other values)
- W_Y, 40, result/accumulator width
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operand set a/b/c/e present
- in_ready  out  1  block idle and able to accept (combinational from state)
- a, b, c  in  12 each  unsigned operands, sampled only on accept
- e  in  1  mode: 1 = accumulate (y += a*b*c), 0 = overwrite (y = a*b*c)
- clr  in  1  synchronous clear of y; honoured only in IDLE
- out_valid  out  1  one-cycle pulse, y freshly updated
- y  out  40  result/accumulator register

## Operation
- Reset (rst_n=0): state=IDLE, cnt=0, internal product/operand regs=0, y=0, out_valid=0. Reset mid-operation aborts the operation; no out_valid is produced.
- States: IDLE, MUL1, MUL2, WB.
- IDLE: in_ready=1. Accept = in_valid & in_ready at a rising edge. On accept: capture a, b, c, e; clear the partial product P; cnt=0; go to MUL1.
- MUL1: each edge processes bit cnt of b, LSB first: P += (b[cnt] ? a<<cnt : 0). P is 24 bits. At cnt=11: latch P1=P, clear P, cnt=0, go to MUL2. Otherwise cnt+1.
- MUL2: each edge processes bit cnt of c: P += (c[cnt] ? P1<<cnt : 0). P is 36 bits. At cnt=11, go to WB.
- WB: one edge. y <= e ? (y + zero-extended P) mod 2^40 : zero-extended P. Set out_valid<=1 and go to IDLE.
- out_valid is cleared on the next edge unconditionally.
- All arithmetic is unsigned. The 36-bit product never overflows (max 0xF_FD00_2FFF). Accumulation wraps silently at 2^40.
- While busy, in_ready=0 and in_valid/a/b/c/e changes are ignored. Captured operands stay stable for the whole operation.
- clr in IDLE: y<=0 at the next edge.
- clr with accept on the same edge: y clears, the operation starts, and WB accumulates onto 0.
- clr while busy: ignored, not queued.
- y changes only at WB, on clr, or on reset. Otherwise it holds its value indefinitely.

## Timing
- Accept at edge k. MUL1 covers edges k+1..k+12. MUL2 covers edges k+13..k+24. WB update is at edge k+25.
- After edge k+25: out_valid=1, y=new value, in_ready=1, all in the same cycle.
- Next accept is possible at edge k+26, where out_valid falls. Throughput is 1 op per 26 cycles; latency from accept to result is 25 edges.
- in_ready drops in the cycle after the accept edge and stays low for 25 cycles.
- No combinational path exists from a/b/c/e to any output. in_ready depends only on state.

## Test plan
- Reset then idle: rst_n low for 3 cycles, then released. Required: y=0, out_valid=0, in_ready=1; outputs hold with in_valid=0 for 50 cycles.
- Overwrite: a=0x76C, b=0x020, c=0x0A5, e=0, accept at edge k. Required: exactly one out_valid pulse, after edge k+25; y=40'h00_0099_1380; in_ready low during edges k+1..k+25.
- Accumulate back-to-back: repeat the same operands with e=1, with in_valid held high. Required: accepts at k+26; y=40'h00_0132_2700 after edge k+51; operand changes made while busy have no effect on the result.
- Max and wrap: clr; then 17 ops with a=b=c=0xFFF, e=1. Required: after the 1st op y=40'h0F_FD00_2FFF; after the 16th y=40'hFF_D002_FFF0; after the 17th y=40'h0F_CD03_2FEF (wrapped).
- clr interactions: clr asserted mid-MUL2 leaves y unchanged. clr together with an accept of a=1, b=1, c=1, e=1 gives y=1 after WB.
- Reset mid-op: pull rst_n low at edge k+10 of an operation. Required: y=0, out_valid stays 0 with no stray pulse, in_ready=1 once rst_n is released, and the next operation computes correctly.
